// File: rtl/prog_counter_pkg.sv
// Shared constants for the programmable up/down counter and its optional prescaler.
package prog_counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_LOAD = 2'd1,
    ACT_STEP = 2'd2
  } action_e;

endpackage

// File: rtl/prog_counter_prescaler.sv
// Step prescaler: asserts tick on every Prescale-th enabled cycle.
// The phase holds while enable is low and restarts from zero on restart.
module prog_counter_prescaler #(
  parameter int Prescale = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int PW = (Prescale > 2) ? $clog2(Prescale) : 1;
  localparam logic [PW-1:0] LAST = PW'(Prescale - 1);

  logic [PW-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (restart) begin
      phase_d = '0;
    end else if (enable) begin
      phase_d = (phase_q == LAST) ? '0 : phase_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign tick = enable && (phase_q == LAST);

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with wrap/saturate modes, terminal pulse and sticky overflow.
// Optional step prescaler enabled by defining PROG_COUNTER_PRESCALE_EN.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int Size     = 5,
  parameter int Prescale = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            up,
  input  logic            mode,
  input  logic            load,
  input  logic [Size-1:0] load_value,
  input  logic [Size-1:0] limit,
  input  logic            clear_overflow,
  output logic [Size-1:0] count,
  output logic            terminal,
  output logic            overflow
);

  logic [Size-1:0] count_q, count_d;
  logic            terminal_q, terminal_d;
  logic            overflow_q, overflow_d;
  logic            tick;
  logic            boundary;
  action_e         action;

`ifdef PROG_COUNTER_PRESCALE_EN
  prog_counter_prescaler #(
    .Prescale (Prescale)
  ) u_prescaler (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .restart (load),
    .tick    (tick)
  );
`else
  logic unused_prescale;
  assign unused_prescale = |32'(Prescale);
  assign tick = 1'b1;
`endif

  always_comb begin
    action = ACT_HOLD;
    if (load) begin
      action = ACT_LOAD;
    end else if (enable && tick) begin
      action = ACT_STEP;
    end
  end

  // A boundary is an up step at/above limit or a down step at zero; the
  // up test uses >= so a limit lowered below count still counts as one.
  always_comb begin
    count_d    = count_q;
    boundary   = 1'b0;
    case (action)
      ACT_LOAD: count_d = (load_value > limit) ? limit : load_value;
      ACT_STEP: begin
        if (up == DIR_UP) begin
          if (count_q >= limit) begin
            boundary = 1'b1;
            count_d  = (mode == MODE_SAT) ? limit : '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end else begin
          if (count_q == '0) begin
            boundary = 1'b1;
            count_d  = (mode == MODE_WRAP) ? limit : '0;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
      end
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    terminal_d = boundary;
    overflow_d = overflow_q;
    if (clear_overflow) begin
      overflow_d = 1'b0;
    end
    if (boundary) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      terminal_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      terminal_q <= terminal_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign terminal = terminal_q;
  assign overflow = overflow_q;

endmodule
